// File: rtl/mux_pkg.sv
// Shared types for the N:1 round-robin / fixed-select channel multiplexer.
package mux_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mux_mode_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = SEL_W'((32'(ptr) + k) % N);
      if (!gnt_any && req[cand]) begin
        grant[cand] = 1'b1;
        gnt_idx     = cand;
        gnt_any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_nto1.sv
// N:1 valid/ready channel multiplexer with round-robin or fixed-select arbitration
// feeding a single registered output stage.
module mux_rr_nto1
  import mux_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_ch,
  input  logic                 out_ready
);

  logic [N-1:0]     rr_grant, fix_grant, grant;
  logic [SEL_W-1:0] rr_idx, fix_idx, gnt_idx, ptr_nxt;
  logic             rr_any, fix_any, gnt_any;
  logic             load, xfer;
  logic [WIDTH-1:0] gnt_data;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_ch_q;
  logic [SEL_W-1:0] ptr_q;

  rr_arbiter #(
    .N (N)
  ) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (ptr_q),
    .grant   (rr_grant),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // sel values beyond N-1 match no channel, so they yield no grant.
  always_comb begin
    fix_grant = '0;
    fix_idx   = sel;
    fix_any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) begin
        fix_grant[i] = 1'b1;
        fix_any      = 1'b1;
      end
    end
  end

  always_comb begin
    if (mux_mode_t'(mode) == MODE_FIXED) begin
      grant   = fix_grant;
      gnt_idx = fix_idx;
      gnt_any = fix_any;
    end else begin
      grant   = rr_grant;
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // No input is accepted while reset is asserted.
  assign load     = ~out_valid_q | out_ready;
  assign xfer     = gnt_any & load & rst_n;
  assign in_ready = grant & {N{load & rst_n}};
  assign ptr_nxt  = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= gnt_data;
      out_ch_q    <= gnt_idx;
      ptr_q       <= ptr_nxt;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Scoreboard bench for mux_rr_nto1: a behavioural model predicts each accepted word,
// a monitor compares it when the DUT presents it.
module tb_mux_rr_nto1;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   ch;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [1:0]     sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_ready;

  logic [W-1:0]   dat [N];
  logic [N-1:0]   took;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  bit   m_valid;
  int   m_ptr;

  mux_rr_nto1 #(
    .N     (N),
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
  end

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endfunction

  // Reference model: decides the winner from the arbitration rules and predicts
  // the word that must appear at the output one edge later.
  always @(negedge clk) begin
    int           g;
    int           c;
    bit           ld;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      exp_q.delete();
      took    = '0;
      check("in_ready_in_reset", 32'(in_ready), 0);
    end else begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      ld = !m_valid || out_ready;
      g  = -1;
      if (mode == 1'b0) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (g < 0 && in_valid[c]) g = c;
        end
      end else if (int'(sel) < N && in_valid[sel]) begin
        g = int'(sel);
      end
      exp_rdy = '0;
      if (g >= 0 && ld) exp_rdy[g] = 1'b1;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      took = in_valid & in_ready;
      if (g >= 0 && ld) begin
        e.data  = dat[g];
        e.ch    = 2'(g);
        exp_q.push_back(e);
        m_valid = 1'b1;
        m_ptr   = (g + 1) % N;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: every presented word must match the oldest outstanding prediction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got ch %0d data %0h expected none", out_ch, out_data);
      end else begin
        e = exp_q[0];
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_ch", 32'(out_ch), 32'(e.ch));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < N; i++) dat[i] = 8'hA0 + 8'(i);
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    set_ramp();
    cyc(2);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_ch", 32'(out_ch), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;

    // Round-robin fairness with every channel requesting.
    cyc(1);
    check("first_grant_ch", 32'(out_ch), 0);
    check("first_grant_data", 32'(out_data), 32'h A0);
    cyc(7);

    // Skip/wrap: move ptr to 1 via ch0, then only ch0 and ch3 request.
    in_valid = 4'b0000;
    cyc(2);
    in_valid = 4'b0001;
    cyc(1);
    in_valid = 4'b1001;
    cyc(1);
    check("skip_first_ch3", 32'(out_ch), 3);
    cyc(1);
    check("skip_then_ch0", 32'(out_ch), 0);
    cyc(1);
    check("skip_then_ch3", 32'(out_ch), 3);
    cyc(1);

    // Fixed select on channel 2, then withdraw channel 2 and drain.
    mode     = 1'b1;
    sel      = 2'd2;
    in_valid = 4'b1111;
    cyc(5);
    in_valid = 4'b1011;
    cyc(3);
    check("fixed_drained", 32'(out_valid), 0);

    // Backpressure with a held word, then release with no bubble.
    mode     = 1'b0;
    in_valid = 4'b1111;
    cyc(1);
    out_ready = 1'b0;
    cyc(3);
    check("bp_out_valid", 32'(out_valid), 1);
    check("bp_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    cyc(3);

    // Randomised traffic; producers hold a request until it is accepted.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (took[i] || !in_valid[i]) begin
          in_valid[i] = 1'($urandom_range(0, 1));
          dat[i]      = 8'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
      cyc(1);
    end

    // Reset asserted mid-cycle while a word is stalled.
    set_ramp();
    mode      = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 0);
    cyc(1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    check("post_rst_first_ch", 32'(out_ch), 0);
    cyc(5);

    in_valid = 4'b0000;
    cyc(3);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_nto1.md
Name: mux_rr_nto1

Overview:
Parametrised N:1 channel multiplexer with valid/ready handshake on every input and on the output, plus a registered output stage. Two modes: round-robin arbitration across all requesting channels, or fixed selection by a select input (the generalisation of the plain 4:1 mux). It sits between multiple producers and a single shared consumer, e.g. funnelling several datapath result streams onto one writeback or bus port.

Parameters:
N, 4, number of input channels (>= 2)
WIDTH, 8, data width per channel in bits
SEL_W, $clog2(N), channel index width (derived; not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = round-robin (MODE_RR), 1 = fixed select (MODE_FIXED)
sel  input  SEL_W  channel index used in MODE_FIXED
in_valid  input  N  per-channel request; bit i belongs to channel i
in_data  input  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
in_ready  output  N  per-channel accept; a transfer occurs when in_valid[i] & in_ready[i]
out_valid  output  1  output register holds valid data
out_data  output  WIDTH  registered data
out_ch  output  SEL_W  source channel index of out_data
out_ready  input  1  consumer accept; a transfer occurs when out_valid & out_ready

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_data=0, out_ch=0, RR pointer ptr=0. in_ready is combinational and is 0 while out_valid=0 and no grant exists.
- Stage enable: load = ~out_valid | out_ready. in_ready[i] = grant[i] & load. At most one in_ready bit is high per cycle.
- MODE_RR grant:
  - Grant the first channel with in_valid set, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap mod N).
  - No requests -> no grant.
- MODE_FIXED grant: grant[sel] = in_valid[sel]. If sel >= N (only possible when N is not a power of 2), there is no grant.
- On an input transfer from channel g:
  - At the next edge, out_data = in_data[g], out_ch = g, out_valid = 1.
  - ptr = (g+1) mod N. ptr updates in both modes, so RR resumes fairly after a mode switch.
- Output drain: if out_valid & out_ready and no input transfer occurs that cycle, out_valid -> 0. out_data/out_ch hold their last value.
- Throughput: one word per cycle sustained when out_ready=1. Latency from input transfer to out_valid is 1 cycle.
- Backpressure: out_valid & ~out_ready -> in_ready all 0. out_data, out_ch, out_valid and ptr all hold.
- Mode and sel are sampled combinationally every cycle. Changing them while the output is stalled has no effect on the held word.
- Input data on non-granted channels is ignored. The producer must hold in_valid/in_data until its transfer.
- Reset asserted mid-stream: the held word is discarded immediately (out_valid=0 asynchronously) and ptr returns to 0.

Decomposition:
- Package mux_pkg: mode constants MODE_RR=1'b0 and MODE_FIXED=1'b1 as a typedef'd enum mux_mode_t.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr[SEL_W]; outputs grant[N] one-hot, gnt_idx[SEL_W], gnt_any. Purely combinational.
- Top level holds the mode mux of the grant, ptr register, output register and handshake logic.

Test Plan:
- Reset: rst_n=0 while all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0000. After release, the first grant goes to ch0.
- RR fairness: N=4, WIDTH=8, all in_valid=1, in_data ch i = 8'hA0+i, out_ready=1.
  - Expect out_ch sequence 0,1,2,3,0 with out_data A0,A1,A2,A3,A0.
  - Expect one word per cycle after 1-cycle latency.
- RR skip/wrap: in_valid=4'b1001, ptr=1 -> ch3 granted first, then ch0, then ch3.
- Fixed mode: mode=1, sel=2, in_valid=4'b1111 -> only in_ready[2] pulses. Every output has out_ch=2, out_data=A2. Set in_valid[2]=0 -> no transfers, out_valid drops after drain.
- Backpressure: out_ready=0 for 3 cycles with a word held -> out_valid=1, out_data/out_ch stable, in_ready=0. Set out_ready=1 -> held word transfers and the next word loads the same cycle (no bubble).
- Mid-stream reset: assert rst_n=0 during a stalled out_valid=1 -> out_valid=0 without a clock edge. After release, the RR order restarts at ch0.
